// File: rtl/proc_pkg.sv
// Shared processor types: FSM states, instruction field positions and fetch defaults.
package proc_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DELIVER, HALTED} state_t;

  localparam logic [5:0]  HALT_OP  = 6'b111111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned JUMP_MSB   = 25;
  localparam int unsigned JUMP_LSB   = 0;
  localparam int unsigned BRANCH_MSB = 15;
  localparam int unsigned BRANCH_LSB = 0;

endpackage

// File: rtl/instr_fetch_if.sv
// PC, instruction-memory and decoded-field signals of the fetch unit.
interface instr_fetch_if;
  logic [31:0] endereco;
  logic        stall_ext;
  logic        halt;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [25:0] endJump;
  logic [15:0] endBranch;
  logic        fetch_err;

  modport master (
    input  endereco, stall_ext, mem_ack, mem_rdata,
    output halt, mem_req, mem_addr, instr, instr_valid, opcode, endJump, endBranch, fetch_err
  );

  modport slave (
    output endereco, stall_ext, mem_ack, mem_rdata,
    input  halt, mem_req, mem_addr, instr, instr_valid, opcode, endJump, endBranch, fetch_err
  );
endinterface

// File: rtl/fetch_timeout.sv
// Wait-cycle counter for a pending fetch; expired flags the last allowed FETCH cycle.
module fetch_timeout
  import proc_pkg::*;
#(
  parameter int unsigned Limit = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Counter holds cycles already spent, so Limit-1 marks the Limit-th request cycle.
  assign o_expired = i_enable && (r_cnt == CNT_W'(Limit - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch responder: req/ack read of instruction memory, instruction register,
// and the halt handshake that lets the PC advance once per delivered instruction.
module instr_fetch #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [5:0]  HALT_OP  = proc_pkg::HALT_OP,
  parameter logic [31:0] NOP_WORD = proc_pkg::NOP_WORD
) (
  input logic           clock,
  input logic           reset,
  instr_fetch_if.master bus
);

  proc_pkg::state_t r_state;
  logic [31:0]      r_instr;
  logic [31:0]      r_mem_addr;
  logic             r_err;

  logic w_in_fetch;
  logic w_ack;
  logic w_expired;
  logic w_advance;

  assign w_in_fetch = (r_state == proc_pkg::FETCH);
  assign w_ack      = w_in_fetch && bus.mem_ack;
  assign w_advance  = (r_state == proc_pkg::DELIVER) && !bus.stall_ext &&
                      (r_instr[proc_pkg::OPCODE_MSB:proc_pkg::OPCODE_LSB] != HALT_OP);

  fetch_timeout #(
    .Limit (TIMEOUT)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!w_in_fetch || w_ack),
    .i_enable  (w_in_fetch),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= proc_pkg::IDLE;
      r_instr    <= '0;
      r_mem_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        proc_pkg::IDLE: begin
          r_state    <= proc_pkg::FETCH;
          r_mem_addr <= bus.endereco;
        end
        proc_pkg::FETCH: begin
          r_mem_addr <= bus.endereco;
          if (bus.mem_ack) begin
            r_instr <= bus.mem_rdata;
            r_state <= proc_pkg::DELIVER;
          end else if (w_expired) begin
            r_instr <= NOP_WORD;
            r_err   <= 1'b1;
            r_state <= proc_pkg::DELIVER;
          end
        end
        proc_pkg::DELIVER: begin
          if (!bus.stall_ext) begin
            if (r_instr[proc_pkg::OPCODE_MSB:proc_pkg::OPCODE_LSB] == HALT_OP) begin
              r_state <= proc_pkg::HALTED;
            end else begin
              r_state    <= proc_pkg::FETCH;
              r_mem_addr <= bus.endereco;
            end
          end
        end
        proc_pkg::HALTED: r_state <= proc_pkg::HALTED;
        default:          r_state <= proc_pkg::IDLE;
      endcase
    end
  end

  // The PC moves on the same edge that leaves DELIVER, so the address is taken live in FETCH.
  assign bus.mem_addr    = w_in_fetch ? bus.endereco : r_mem_addr;
  assign bus.mem_req     = w_in_fetch;
  assign bus.halt        = !w_advance;
  assign bus.instr_valid = (r_state == proc_pkg::DELIVER) || (r_state == proc_pkg::HALTED);
  assign bus.instr       = r_instr;
  assign bus.fetch_err   = r_err;
  assign bus.opcode      = r_instr[proc_pkg::OPCODE_MSB:proc_pkg::OPCODE_LSB];
  assign bus.endJump     = r_instr[proc_pkg::JUMP_MSB:proc_pkg::JUMP_LSB];
  assign bus.endBranch   = r_instr[proc_pkg::BRANCH_MSB:proc_pkg::BRANCH_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC and wait-state memory models, per-cycle vector table, corner sequences.
module tb_instr_fetch;

  logic        clock;
  logic        reset;
  logic        force_ack;
  int unsigned mem_wait;
  int unsigned req_cnt;
  logic [31:0] mem [16];
  int          checks;
  int          errors;

  instr_fetch_if bus ();

  instr_fetch #(
    .TIMEOUT (15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PC model: advances only on edges where halt is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bus.endereco <= '0;
    else if (!bus.halt) bus.endereco <= bus.endereco + 32'd1;
  end

  // Memory model: acks after mem_wait request cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) req_cnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  end

  always_comb begin
    bus.mem_ack   = force_ack || (bus.mem_req && (req_cnt >= mem_wait));
    bus.mem_rdata = mem[bus.mem_addr[3:0]];
  end

  typedef struct {
    logic        stall;
    int unsigned mwait;
    logic        req;
    logic        halt;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b0;
    force_ack = 1'b0;
    bus.stall_ext = 1'b0;
    mem_wait  = 0;
    #1;
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_halt", {31'd0, bus.halt}, 32'd1);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_err", {31'd0, bus.fetch_err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    force_ack = 1'b0;
    bus.stall_ext = 1'b0;
    mem_wait = 0;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0] = 32'h2000_0005;
    mem[1] = 32'h0800_0123;
    mem[2] = 32'h1234_ABCD;
    mem[3] = 32'hFC00_0000;

    //            stall wait req halt valid addr  instr
    vecs[0]  = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h2000_0005};
    vecs[2]  = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 32'd1, 32'h2000_0005};
    vecs[3]  = '{1'b0, 3, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0800_0123};
    vecs[4]  = '{1'b0, 3, 1'b1, 1'b1, 1'b0, 32'd2, 32'h0800_0123};
    vecs[5]  = '{1'b0, 3, 1'b1, 1'b1, 1'b0, 32'd2, 32'h0800_0123};
    vecs[6]  = '{1'b0, 3, 1'b1, 1'b1, 1'b0, 32'd2, 32'h0800_0123};
    vecs[7]  = '{1'b0, 3, 1'b1, 1'b1, 1'b0, 32'd2, 32'h0800_0123};
    vecs[8]  = '{1'b1, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'h1234_ABCD};
    vecs[9]  = '{1'b1, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'h1234_ABCD};
    vecs[10] = '{1'b1, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'h1234_ABCD};
    vecs[11] = '{1'b1, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'h1234_ABCD};
    vecs[12] = '{1'b1, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'h1234_ABCD};
    vecs[13] = '{1'b0, 0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h1234_ABCD};
    vecs[14] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 32'd3, 32'h1234_ABCD};
    vecs[15] = '{1'b0, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'hFC00_0000};
    vecs[16] = '{1'b0, 0, 1'b0, 1'b1, 1'b1, 32'd0, 32'hFC00_0000};

    do_reset();

    // Zero-wait fetches, 3-wait fetch, 5-cycle stall, then a HALT instruction.
    for (int i = 0; i < 17; i++) begin
      @(posedge clock);
      @(negedge clock);
      bus.stall_ext = vecs[i].stall;
      mem_wait      = vecs[i].mwait;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, bus.mem_req}, {31'd0, vecs[i].req});
      chk($sformatf("v%0d_halt", i), {31'd0, bus.halt}, {31'd0, vecs[i].halt});
      chk($sformatf("v%0d_valid", i), {31'd0, bus.instr_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d_instr", i), bus.instr, vecs[i].instr);
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].addr);
      if (i == 1) chk("v1_branch", {16'd0, bus.endBranch}, 32'h0000_0005);
      if (i == 15) chk("v15_opcode", {26'd0, bus.opcode}, 32'h0000_003F);
    end

    // HALTED must hold for good.
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("halted_req", {31'd0, bus.mem_req}, 32'd0);
      chk("halted_halt", {31'd0, bus.halt}, 32'd1);
      chk("halted_instr", bus.instr, 32'hFC00_0000);
    end
    chk("halted_pc", bus.endereco, 32'd3);

    do_reset();

    // Memory never acks: exactly 15 request cycles, then NOP and sticky error.
    mem_wait = 99;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (!bus.mem_req) break;
      n++;
    end
    chk("to_req_cycles", n, 32'd15);
    chk("to_instr", bus.instr, 32'h0);
    chk("to_err", {31'd0, bus.fetch_err}, 32'd1);
    chk("to_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("to_halt", {31'd0, bus.halt}, 32'd0);
    bus.stall_ext = 1'b1;
    force_ack     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("late_ack_instr", bus.instr, 32'h0);
    chk("late_ack_valid", {31'd0, bus.instr_valid}, 32'd1);
    bus.stall_ext = 1'b0;
    force_ack     = 1'b0;
    mem_wait      = 0;
    @(posedge clock);
    @(negedge clock);
    chk("after_to_req", {31'd0, bus.mem_req}, 32'd1);
    chk("after_to_addr", bus.mem_addr, 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk("after_to_instr", bus.instr, 32'h0800_0123);
    chk("err_sticky", {31'd0, bus.fetch_err}, 32'd1);

    // Reset in the middle of a waiting fetch.
    mem_wait = 99;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("mid_req", {31'd0, bus.mem_req}, 32'd1);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mid_rst_instr", bus.instr, 32'h0);
    chk("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, bus.fetch_err}, 32'd0);
    @(negedge clock);
    mem_wait = 0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("restart_req", {31'd0, bus.mem_req}, 32'd1);
    chk("restart_addr", bus.mem_addr, 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("restart_instr", bus.instr, 32'h2000_0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
